// File: rtl/writeback_rr_arbiter.sv
// Round-robin arbiter funnelling many IO responders into one registered writeback slot.
// The most recently granted port drops to lowest priority; one transfer per cycle when the sink is ready.
module writeback_rr_arbiter #(
  parameter int DATABITWIDTH    = 16,
  parameter int INPUTPORTCOUNT  = 13,
  parameter int PORTADDRWIDTH   = $clog2(INPUTPORTCOUNT),
  parameter int REGADDRBITWIDTH = 4
) (
  input  logic                                           sys_clk,
  input  logic                                           sync_rst,
  input  logic                                           clk_en,
  input  logic [INPUTPORTCOUNT-1:0]                      InputACK,
  output logic [INPUTPORTCOUNT-1:0]                      InputREQ,
  input  logic [INPUTPORTCOUNT-1:0][DATABITWIDTH-1:0]    InputData,
  input  logic [INPUTPORTCOUNT-1:0][REGADDRBITWIDTH-1:0] InputAddr,
  output logic                                           OutputACK,
  input  logic                                           OutputREQ,
  output logic [DATABITWIDTH-1:0]                        OutputData,
  output logic [REGADDRBITWIDTH-1:0]                     OutputAddr,
  output logic [PORTADDRWIDTH-1:0]                       GrantPort
);

  localparam logic [PORTADDRWIDTH-1:0] LAST_PORT = PORTADDRWIDTH'(INPUTPORTCOUNT - 1);

  logic                       full_q, full_d;
  logic [PORTADDRWIDTH-1:0]   ptr_q, ptr_d;
  logic [DATABITWIDTH-1:0]    data_q, data_d;
  logic [REGADDRBITWIDTH-1:0] addr_q, addr_d;
  logic [PORTADDRWIDTH-1:0]   port_q, port_d;

  logic                       load;
  logic                       any_ack;
  logic [PORTADDRWIDTH-1:0]   grant_sel;
  logic [PORTADDRWIDTH-1:0]   cand;

  // Rotation wraps at the port count, not at the power of two above it.
  function automatic logic [PORTADDRWIDTH-1:0] wrap_idx(input logic [PORTADDRWIDTH-1:0] base,
                                                        input int off);
    int s;
    s = int'(base) + off;
    if (s >= INPUTPORTCOUNT) s = s - INPUTPORTCOUNT;
    return PORTADDRWIDTH'(s);
  endfunction

  assign load = clk_en & ~sync_rst & (~full_q | OutputREQ);

  always_comb begin
    any_ack   = 1'b0;
    grant_sel = '0;
    cand      = '0;
    for (int k = 0; k < INPUTPORTCOUNT; k++) begin
      cand = wrap_idx(ptr_q, k);
      if (!any_ack && InputACK[cand]) begin
        any_ack   = 1'b1;
        grant_sel = cand;
      end
    end
  end

  always_comb begin
    InputREQ = '0;
    if (load && any_ack) InputREQ[grant_sel] = 1'b1;
  end

  always_comb begin
    full_d = full_q;
    ptr_d  = ptr_q;
    data_d = data_q;
    addr_d = addr_q;
    port_d = port_q;
    if (load) begin
      full_d = any_ack;
      if (any_ack) begin
        data_d = InputData[grant_sel];
        addr_d = InputAddr[grant_sel];
        port_d = grant_sel;
        ptr_d  = (grant_sel == LAST_PORT) ? '0 : grant_sel + PORTADDRWIDTH'(1);
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sync_rst) begin
      full_q <= 1'b0;
      ptr_q  <= '0;
      data_q <= '0;
      addr_q <= '0;
      port_q <= '0;
    end else begin
      full_q <= full_d;
      ptr_q  <= ptr_d;
      data_q <= data_d;
      addr_q <= addr_d;
      port_q <= port_d;
    end
  end

  assign OutputACK  = full_q;
  assign OutputData = data_q;
  assign OutputAddr = addr_q;
  assign GrantPort  = port_q;

endmodule

// File: tb/tb_writeback_rr_arbiter.sv
// Bench for writeback_rr_arbiter: hand-derived vector table, round-robin sweep and random traffic
// checked against a one-entry scoreboard of expected output-register contents.
module tb_writeback_rr_arbiter;
  localparam int N  = 13;
  localparam int DW = 16;
  localparam int AW = 4;
  localparam int PW = 4;

  logic                   sys_clk = 1'b0;
  logic                   sync_rst;
  logic                   clk_en;
  logic [N-1:0]           InputACK;
  logic [N-1:0]           InputREQ;
  logic [N-1:0][DW-1:0]   InputData;
  logic [N-1:0][AW-1:0]   InputAddr;
  logic                   OutputACK;
  logic                   OutputREQ;
  logic [DW-1:0]          OutputData;
  logic [AW-1:0]          OutputAddr;
  logic [PW-1:0]          GrantPort;

  writeback_rr_arbiter #(
    .DATABITWIDTH(DW), .INPUTPORTCOUNT(N), .PORTADDRWIDTH(PW), .REGADDRBITWIDTH(AW)
  ) dut (
    .sys_clk(sys_clk), .sync_rst(sync_rst), .clk_en(clk_en),
    .InputACK(InputACK), .InputREQ(InputREQ), .InputData(InputData), .InputAddr(InputAddr),
    .OutputACK(OutputACK), .OutputREQ(OutputREQ), .OutputData(OutputData),
    .OutputAddr(OutputAddr), .GrantPort(GrantPort)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [AW-1:0] a;
    logic [PW-1:0] p;
  } ent_t;

  typedef struct {
    logic [N-1:0] ack;
    logic         oreq;
    logic         en;
    logic         rst;
    logic [N-1:0] req;
    logic         oack;
    logic [PW-1:0] port;
    logic         zero;
  } vec_t;

  ent_t sbq[$];
  int   ptr_m;
  int   nvec;
  int   nerr;
  bit   rand_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_grant(input logic [N-1:0] ack);
    int idx;
    for (int k = 0; k < N; k++) begin
      idx = (ptr_m + k) % N;
      if (ack[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic cycle(input logic [N-1:0] ack, input logic oreq, input logic en, input logic rst,
                       output logic [N-1:0] req_s, output logic oack_s, output logic [PW-1:0] port_s,
                       output logic [DW-1:0] od_s, output logic [AW-1:0] oa_s);
    int           g;
    logic         full;
    logic         load;
    logic [N-1:0] exp_req;
    ent_t         e;
    @(negedge sys_clk);
    InputACK  = ack;
    OutputREQ = oreq;
    clk_en    = en;
    sync_rst  = rst;
    if (rand_data) begin
      for (int i = 0; i < N; i++) begin
        InputData[i] = DW'($urandom);
        InputAddr[i] = AW'($urandom);
      end
    end
    #1;
    full    = (sbq.size() != 0);
    load    = en & ~rst & (~full | oreq);
    g       = model_grant(ack);
    exp_req = '0;
    if (load && g >= 0) exp_req[g] = 1'b1;
    req_s  = InputREQ;
    oack_s = OutputACK;
    port_s = GrantPort;
    od_s   = OutputData;
    oa_s   = OutputAddr;
    check("InputREQ", 32'(InputREQ), 32'(exp_req));
    check("OutputACK", 32'(OutputACK), 32'(full));
    if (full) begin
      check("OutputData", 32'(OutputData), 32'(sbq[0].d));
      check("OutputAddr", 32'(OutputAddr), 32'(sbq[0].a));
      check("GrantPort", 32'(GrantPort), 32'(sbq[0].p));
    end
    @(posedge sys_clk);
    if (rst) begin
      sbq.delete();
      ptr_m = 0;
    end else if (load) begin
      if (full) void'(sbq.pop_front());
      if (g >= 0) begin
        e.d = InputData[g];
        e.a = InputAddr[g];
        e.p = PW'(g);
        sbq.push_back(e);
        ptr_m = (g == N - 1) ? 0 : g + 1;
      end
    end
  endtask

  vec_t          tbl[20];
  logic [N-1:0]  req_s;
  logic          oack_s;
  logic [PW-1:0] port_s;
  logic [DW-1:0] od_s;
  logic [AW-1:0] oa_s;

  initial begin
    nvec = 0;
    nerr = 0;
    ptr_m = 0;
    rand_data = 1'b0;
    sync_rst = 1'b1;
    clk_en = 1'b1;
    OutputREQ = 1'b0;
    InputACK = '0;
    for (int i = 0; i < N; i++) begin
      InputData[i] = DW'(16'hBE00 + i);
      InputAddr[i] = AW'(i);
    end
    InputData[5] = 16'hBEEF;
    InputAddr[5] = 4'd3;

    //            ack       oreq  en    rst   req       oack  port  zero
    tbl[0]  = '{13'h0020, 1'b1, 1'b1, 1'b0, 13'h0020, 1'b0, 4'd0,  1'b0};
    tbl[1]  = '{13'h0000, 1'b1, 1'b1, 1'b0, 13'h0000, 1'b1, 4'd5,  1'b0};
    tbl[2]  = '{13'h0084, 1'b1, 1'b1, 1'b0, 13'h0080, 1'b0, 4'd0,  1'b0};
    tbl[3]  = '{13'h0084, 1'b0, 1'b1, 1'b0, 13'h0000, 1'b1, 4'd7,  1'b0};
    tbl[4]  = '{13'h0084, 1'b0, 1'b1, 1'b0, 13'h0000, 1'b1, 4'd7,  1'b0};
    tbl[5]  = '{13'h0084, 1'b1, 1'b1, 1'b0, 13'h0004, 1'b1, 4'd7,  1'b0};
    tbl[6]  = '{13'h0080, 1'b1, 1'b1, 1'b0, 13'h0080, 1'b1, 4'd2,  1'b0};
    tbl[7]  = '{13'h0000, 1'b1, 1'b1, 1'b0, 13'h0000, 1'b1, 4'd7,  1'b0};
    tbl[8]  = '{13'h0800, 1'b1, 1'b1, 1'b0, 13'h0800, 1'b0, 4'd0,  1'b0};
    tbl[9]  = '{13'h1001, 1'b1, 1'b1, 1'b0, 13'h1000, 1'b1, 4'd11, 1'b0};
    tbl[10] = '{13'h0001, 1'b1, 1'b1, 1'b0, 13'h0001, 1'b1, 4'd12, 1'b0};
    tbl[11] = '{13'h0006, 1'b1, 1'b0, 1'b0, 13'h0000, 1'b1, 4'd0,  1'b0};
    tbl[12] = '{13'h0006, 1'b1, 1'b0, 1'b0, 13'h0000, 1'b1, 4'd0,  1'b0};
    tbl[13] = '{13'h0006, 1'b1, 1'b0, 1'b0, 13'h0000, 1'b1, 4'd0,  1'b0};
    tbl[14] = '{13'h0006, 1'b1, 1'b1, 1'b0, 13'h0002, 1'b1, 4'd0,  1'b0};
    tbl[15] = '{13'h0040, 1'b1, 1'b1, 1'b0, 13'h0040, 1'b1, 4'd1,  1'b0};
    tbl[16] = '{13'h0041, 1'b0, 1'b1, 1'b1, 13'h0000, 1'b1, 4'd6,  1'b0};
    tbl[17] = '{13'h0041, 1'b1, 1'b1, 1'b0, 13'h0001, 1'b0, 4'd0,  1'b1};
    tbl[18] = '{13'h0040, 1'b1, 1'b1, 1'b0, 13'h0040, 1'b1, 4'd0,  1'b0};
    tbl[19] = '{13'h0000, 1'b1, 1'b1, 1'b0, 13'h0000, 1'b1, 4'd6,  1'b0};

    repeat (2) @(posedge sys_clk);
    cycle('0, 1'b0, 1'b1, 1'b1, req_s, oack_s, port_s, od_s, oa_s);
    #1;
    check("rst_OutputACK", 32'(OutputACK), 32'd0);
    check("rst_OutputData", 32'(OutputData), 32'd0);
    check("rst_OutputAddr", 32'(OutputAddr), 32'd0);
    check("rst_GrantPort", 32'(GrantPort), 32'd0);

    for (int i = 0; i < 20; i++) begin
      cycle(tbl[i].ack, tbl[i].oreq, tbl[i].en, tbl[i].rst, req_s, oack_s, port_s, od_s, oa_s);
      check($sformatf("tbl%0d_req", i), 32'(req_s), 32'(tbl[i].req));
      check($sformatf("tbl%0d_oack", i), 32'(oack_s), 32'(tbl[i].oack));
      if (tbl[i].oack) check($sformatf("tbl%0d_port", i), 32'(port_s), 32'(tbl[i].port));
      if (tbl[i].zero) begin
        check($sformatf("tbl%0d_data0", i), 32'(od_s), 32'd0);
        check($sformatf("tbl%0d_addr0", i), 32'(oa_s), 32'd0);
        check($sformatf("tbl%0d_port0", i), 32'(port_s), 32'd0);
      end
      if (i == 1) begin
        check("single_data", 32'(od_s), 32'h0000BEEF);
        check("single_addr", 32'(oa_s), 32'd3);
      end
    end

    // Every port asserting: grants must rotate 0..12 and come back to 0.
    cycle('0, 1'b1, 1'b1, 1'b1, req_s, oack_s, port_s, od_s, oa_s);
    for (int k = 0; k < 14; k++) begin
      cycle({N{1'b1}}, 1'b1, 1'b1, 1'b0, req_s, oack_s, port_s, od_s, oa_s);
      check($sformatf("rr_seq%0d", k), 32'(req_s), 32'(1) << (k % N));
    end

    rand_data = 1'b1;
    for (int k = 0; k < 400; k++) begin
      cycle(N'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 7) != 0,
            $urandom_range(0, 63) == 0, req_s, oack_s, port_s, od_s, oa_s);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
